// File: rtl/reg_array_mem.sv
// reg_array_mem: register-array RAM with a clear sweep after reset, pipelined read-first reads and range checking.
// Optional per-word even parity when REG_ARRAY_PARITY_EN is defined.
module reg_array_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
`ifdef REG_ARRAY_PARITY_EN
  input  logic                  inj_err,
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] qout,
  output logic                  qvalid,
  output logic                  addr_err,
  output logic                  busy
);
  localparam int RL = READ_LATENCY;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] d_q [RL];
  logic [DATA_WIDTH-1:0] d_d [RL];
  logic [RL-1:0] v_q, v_d, e_q, e_d;
  logic werr_q, werr_d;
  logic idle, oob, rd, wr;
  logic [DATA_WIDTH-1:0] rdata;
  assign idle = state_q == IDLE;
  assign oob = {1'b0, addr} >= DEPTH_L;
  assign rd = idle && re;
  assign wr = idle && we && !oob;
  assign rdata = oob ? '0 : mem[addr];
  // valid/error bits shift every enabled cycle; data stages only load behind a valid entry
  always_comb begin
    state_d = (!idle && cnt_q == LAST) ? IDLE : state_q;
    cnt_d = idle ? cnt_q : cnt_q + 1'b1;
    werr_d = idle && we && oob;
    v_d = RL'({v_q, rd});
    e_d = RL'({e_q, rd && oob});
    d_d[0] = rd ? rdata : d_q[0];
    for (int i = 1; i < RL; i++) d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
      v_q <= '0;
      e_q <= '0;
      werr_q <= 1'b0;
      for (int i = 0; i < RL; i++) d_q[i] <= '0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      v_q <= v_d;
      e_q <= e_d;
      werr_q <= werr_d;
      d_q <= d_d;
    end
  end
  // storage is never reset; the sweep alone initialises it
  always_ff @(posedge clk) begin
    if (clken) begin
      if (!idle) mem[cnt_q] <= INIT_VALUE;
      else if (wr) mem[addr] <= data;
    end
  end
  assign qout = d_q[RL-1];
  assign qvalid = v_q[RL-1];
  assign addr_err = werr_q || (v_q[RL-1] && e_q[RL-1]);
  assign busy = !idle;
`ifdef REG_ARRAY_PARITY_EN
  logic par_mem [DEPTH];
  logic [RL-1:0] p_q, p_d;
  assign p_d = RL'({p_q, rd && !oob && (^mem[addr] ^ par_mem[addr])});
  always_ff @(posedge clk) begin
    if (clken) begin
      if (!idle) par_mem[cnt_q] <= ^INIT_VALUE;
      else if (wr) par_mem[addr] <= ^data ^ inj_err;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) p_q <= '0;
    else if (clken) p_q <= p_d;
  end
  assign parity_err = v_q[RL-1] && p_q[RL-1];
`endif
endmodule

// File: tb/tb_reg_array_mem.sv
// tb_reg_array_mem: scoreboard bench driving a latency-1/depth-16 and a latency-2/depth-12 instance in lockstep.
module tb_reg_array_mem;
  typedef struct packed {logic v; logic [7:0] d; logic e; logic b;} ent_t;
  localparam int DEP [2] = '{16, 12};
  localparam int RL [2] = '{1, 2};
  localparam logic [7:0] INIT [2] = '{8'h00, 8'h5A};
  logic clk = 0, rst = 1, clken = 0, we = 0, re = 0;
  logic [3:0] addr = 0;
  logic [7:0] data = 0;
  logic [7:0] qo [2];
  logic qv [2], ae [2], bz [2];
  logic [7:0] mm [2][16];
  int cnt [2];
  logic clr [2], pv [2], pe_m [2];
  logic [7:0] pd [2];
  logic ev [2], ee [2], eb [2];
  logic [7:0] eq [2];
  ent_t sb0 [$], sb1 [$];
  ent_t mx;
  int n_chk = 0, n_fail = 0;
`ifdef REG_ARRAY_PARITY_EN
  logic inj_err = 0;
  logic par [2];
  reg_array_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1), .INIT_VALUE(8'h00)) u0 (
    .clk(clk), .rst(rst), .clken(clken), .we(we), .re(re), .addr(addr), .data(data),
    .inj_err(inj_err), .parity_err(par[0]), .qout(qo[0]), .qvalid(qv[0]), .addr_err(ae[0]), .busy(bz[0]));
  reg_array_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(2), .INIT_VALUE(8'h5A)) u1 (
    .clk(clk), .rst(rst), .clken(clken), .we(we), .re(re), .addr(addr), .data(data),
    .inj_err(inj_err), .parity_err(par[1]), .qout(qo[1]), .qvalid(qv[1]), .addr_err(ae[1]), .busy(bz[1]));
`else
  reg_array_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .READ_LATENCY(1), .INIT_VALUE(8'h00)) u0 (
    .clk(clk), .rst(rst), .clken(clken), .we(we), .re(re), .addr(addr), .data(data),
    .qout(qo[0]), .qvalid(qv[0]), .addr_err(ae[0]), .busy(bz[0]));
  reg_array_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .READ_LATENCY(2), .INIT_VALUE(8'h5A)) u1 (
    .clk(clk), .rst(rst), .clken(clken), .we(we), .re(re), .addr(addr), .data(data),
    .qout(qo[1]), .qvalid(qv[1]), .addr_err(ae[1]), .busy(bz[1]));
`endif
  always #5 clk = ~clk;
  // scoreboard consumer: one popped entry per enabled edge, held expectations otherwise
  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (clken) begin
          if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard dut%0d: queue empty, required one entry", k);
          end else begin
            if (k == 0) mx = sb0.pop_front();
            else mx = sb1.pop_front();
            ev[k] = mx.v; ee[k] = mx.e; eb[k] = mx.b;
            if (mx.v) eq[k] = mx.d;
          end
        end
        n_chk++;
        if (qv[k] !== ev[k]) begin n_fail++; $display("FAIL qvalid dut%0d: got %b required %b", k, qv[k], ev[k]); end
        n_chk++;
        if (ae[k] !== ee[k]) begin n_fail++; $display("FAIL addr_err dut%0d: got %b required %b", k, ae[k], ee[k]); end
        n_chk++;
        if (bz[k] !== eb[k]) begin n_fail++; $display("FAIL busy dut%0d: got %b required %b", k, bz[k], eb[k]); end
        if (ev[k]) begin
          n_chk++;
          if (qo[k] !== eq[k]) begin n_fail++; $display("FAIL qout dut%0d: got %h required %h", k, qo[k], eq[k]); end
        end
      end
    end
  end
  // drive one cycle at the negedge and push the expected post-edge outputs
  task automatic cycle(input logic ce, input logic w, input logic r, input logic [3:0] a, input logic [7:0] dt);
    ent_t e;
    clken = ce; we = w; re = r; addr = a; data = dt;
    if (ce) for (int k = 0; k < 2; k++) begin
      logic rv, rer, wer;
      logic [7:0] rd;
      rv = 0; rer = 0; wer = 0; rd = 8'h00;
      if (clr[k]) begin
        mm[k][cnt[k]] = INIT[k];
        cnt[k]++;
        if (cnt[k] == DEP[k]) clr[k] = 0;
      end else begin
        rv = r;
        rer = r && (a >= DEP[k]);
        rd = (r && a < DEP[k]) ? mm[k][a] : 8'h00;
        wer = w && (a >= DEP[k]);
        if (w && a < DEP[k]) mm[k][a] = dt;
      end
      if (RL[k] == 2) begin
        e = '{pv[k], pd[k], (pv[k] & pe_m[k]) | wer, clr[k]};
        pv[k] = rv; pd[k] = rd; pe_m[k] = rer;
      end else e = '{rv, rd, rer | wer, clr[k]};
      if (k == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    @(negedge clk);
  endtask
  task automatic do_reset(input int hold);
    clken = 0; we = 0; re = 0; rst = 0;
    sb0.delete(); sb1.delete();
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1; cnt[k] = 0; pv[k] = 0; pe_m[k] = 0; pd[k] = 8'h00;
      ev[k] = 0; ee[k] = 0; eb[k] = 1; eq[k] = 8'h00;
    end
    repeat (hold) @(negedge clk);
    rst = 1;
  endtask
  task automatic test_reset;
    #2 rst = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if ({qv[k], ae[k], bz[k], qo[k]} !== {3'b001, 8'h00}) begin
        n_fail++; $display("FAIL reset dut%0d: got v=%b e=%b b=%b q=%h required v=0 e=0 b=1 q=00", k, qv[k], ae[k], bz[k], qo[k]);
      end
    end
    do_reset(2);
  endtask
  task automatic test_clear;
    for (int i = 0; i < 16; i++) begin
      cycle(1, i < 12, 1, 4'(i), 8'hFF);
      n_chk++;
      if (bz[0] !== (i < 15)) begin n_fail++; $display("FAIL clear_busy0 cycle %0d: got %b required %b", i, bz[0], i < 15); end
      n_chk++;
      if (bz[1] !== (i < 11)) begin n_fail++; $display("FAIL clear_busy1 cycle %0d: got %b required %b", i, bz[1], i < 11); end
    end
    for (int a = 0; a < 16; a++) begin
      cycle(1, 0, 1, 4'(a), 8'h00);
      n_chk++;
      if ({qv[0], qo[0]} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL clear_read addr %0d: got v=%b q=%h required v=1 q=00", a, qv[0], qo[0]); end
    end
    cycle(1, 0, 0, 0, 0);
  endtask
  task automatic test_write_read;
    cycle(1, 1, 0, 4'd3, 8'hA5);
    cycle(1, 0, 1, 4'd3, 8'h00);
    n_chk++;
    if ({qv[0], qo[0]} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL wr_rd0: got v=%b q=%h required v=1 q=a5", qv[0], qo[0]); end
    n_chk++;
    if (qv[1] !== 1'b0) begin n_fail++; $display("FAIL wr_rd1_early: got v=%b required v=0", qv[1]); end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if ({qv[1], qo[1]} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL wr_rd1: got v=%b q=%h required v=1 q=a5", qv[1], qo[1]); end
  endtask
  task automatic test_collision;
    cycle(1, 1, 0, 4'd5, 8'h11);
    cycle(1, 1, 1, 4'd5, 8'h3C);
    n_chk++;
    if ({qv[0], qo[0]} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL read_first0: got v=%b q=%h required v=1 q=11", qv[0], qo[0]); end
    cycle(1, 0, 1, 4'd5, 8'h00);
    n_chk++;
    if ({qv[0], qo[0]} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL after_write0: got v=%b q=%h required v=1 q=3c", qv[0], qo[0]); end
    n_chk++;
    if ({qv[1], qo[1]} !== {1'b1, 8'h11}) begin n_fail++; $display("FAIL read_first1: got v=%b q=%h required v=1 q=11", qv[1], qo[1]); end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if ({qv[1], qo[1]} !== {1'b1, 8'h3C}) begin n_fail++; $display("FAIL after_write1: got v=%b q=%h required v=1 q=3c", qv[1], qo[1]); end
  endtask
  task automatic test_addr_err;
    cycle(1, 1, 0, 4'd14, 8'h77);
    n_chk++;
    if ({ae[0], ae[1]} !== 2'b01) begin n_fail++; $display("FAIL wr_oob: got e0=%b e1=%b required e0=0 e1=1", ae[0], ae[1]); end
    cycle(1, 0, 1, 4'd14, 8'h00);
    n_chk++;
    if ({qv[0], qo[0], ae[0], ae[1]} !== {1'b1, 8'h77, 2'b00}) begin
      n_fail++; $display("FAIL rd_14: got v0=%b q0=%h e0=%b e1=%b required v0=1 q0=77 e0=0 e1=0", qv[0], qo[0], ae[0], ae[1]);
    end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if ({qv[1], qo[1], ae[1]} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL rd_oob1: got v=%b q=%h e=%b required v=1 q=00 e=1", qv[1], qo[1], ae[1]);
    end
    cycle(1, 0, 1, 4'd2, 8'h00);
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if ({qv[1], qo[1], ae[1]} !== {1'b1, 8'h5A, 1'b0}) begin
      n_fail++; $display("FAIL alias1: got v=%b q=%h e=%b required v=1 q=5a e=0", qv[1], qo[1], ae[1]);
    end
  endtask
  task automatic test_stall;
    cycle(1, 0, 1, 4'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 4'd7, 8'hEE);
      n_chk++;
      if ({qv[0], qo[0], qv[1]} !== {1'b1, 8'hA5, 1'b0}) begin
        n_fail++; $display("FAIL stall %0d: got v0=%b q0=%h v1=%b required v0=1 q0=a5 v1=0", i, qv[0], qo[0], qv[1]);
      end
    end
    cycle(1, 0, 1, 4'd7, 8'h00);
    n_chk++;
    if ({qv[1], qo[1]} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL stall_release1: got v=%b q=%h required v=1 q=a5", qv[1], qo[1]); end
    n_chk++;
    if ({qv[0], qo[0]} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL stall_nowrite0: got v=%b q=%h required v=1 q=00", qv[0], qo[0]); end
    cycle(1, 0, 0, 0, 0);
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 80; i++)
      cycle($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom));
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
  endtask
  task automatic test_reset_mid_pipe;
    cycle(1, 0, 1, 4'd3, 8'h00);
    rst = 0;
    #1;
    n_chk++;
    if ({qv[0], qv[1], bz[0], bz[1]} !== 4'b0011) begin
      n_fail++; $display("FAIL reset_pipe: got v0=%b v1=%b b0=%b b1=%b required 0 0 1 1", qv[0], qv[1], bz[0], bz[1]);
    end
    do_reset(2);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 0);
      n_chk++;
      if (qv[1] !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_flush %0d: got v1=%b required 0", i, qv[1]); end
    end
  endtask
  task automatic test_reset_mid_clear;
    do_reset(2);
    repeat (5) cycle(1, 0, 0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 0);
      n_chk++;
      if (bz[0] !== (i < 15)) begin n_fail++; $display("FAIL reclear_busy cycle %0d: got %b required %b", i, bz[0], i < 15); end
    end
  endtask
`ifdef REG_ARRAY_PARITY_EN
  task automatic test_parity;
    inj_err = 1;
    cycle(1, 1, 0, 4'd6, 8'h0F);
    inj_err = 0;
    cycle(1, 0, 1, 4'd6, 8'h00);
    n_chk++;
    if ({qv[0], par[0]} !== 2'b11) begin n_fail++; $display("FAIL parity_inj0: got v=%b p=%b required 1 1", qv[0], par[0]); end
    cycle(1, 1, 0, 4'd6, 8'h0F);
    n_chk++;
    if ({qv[1], par[1]} !== 2'b11) begin n_fail++; $display("FAIL parity_inj1: got v=%b p=%b required 1 1", qv[1], par[1]); end
    cycle(1, 0, 1, 4'd6, 8'h00);
    n_chk++;
    if ({qv[0], par[0]} !== 2'b10) begin n_fail++; $display("FAIL parity_ok0: got v=%b p=%b required 1 0", qv[0], par[0]); end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if ({qv[1], par[1]} !== 2'b10) begin n_fail++; $display("FAIL parity_ok1: got v=%b p=%b required 1 0", qv[1], par[1]); end
  endtask
`endif
  initial begin
    test_reset;
    test_clear;
    test_write_read;
    test_collision;
    test_addr_err;
    test_stall;
`ifdef REG_ARRAY_PARITY_EN
    test_parity;
`endif
    test_back_to_back;
    test_reset_mid_pipe;
    test_reset_mid_clear;
    cycle(0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
